// File: rtl/huff_pkg.sv
// huff_pkg: state encoding and width helpers shared by the Huffman table encoder.
package huff_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MERGE, S_WALK, S_EMIT} state_t;
  function automatic int w_w(input int n, input int freq_w);
    return freq_w + $clog2(n);
  endfunction
  function automatic int idx_w(input int n);
    return $clog2(2 * n - 1);
  endfunction
  function automatic int len_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/huff_encoder_param_min2_finder.sv
// huff_min2_finder: picks the two lightest active nodes; ties go to the lower index.
module huff_min2_finder #(
  parameter int M  = 7,
  parameter int W  = 5,
  parameter int IW = 3
) (
  input  logic [M*W-1:0] i_wt,
  input  logic [M-1:0]   i_act,
  output logic [IW-1:0]  o_min1,
  output logic [IW-1:0]  o_min2
);
  logic [W-1:0] w_w1, w_w2;
  logic         w_f1, w_f2;
  always_comb begin
    o_min1 = '0;
    o_min2 = '0;
    w_w1   = '0;
    w_w2   = '0;
    w_f1   = 1'b0;
    w_f2   = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (i_act[i]) begin
        if (!w_f1 || i_wt[i*W +: W] < w_w1) begin
          o_min2 = o_min1;
          w_w2   = w_w1;
          w_f2   = w_f1;
          o_min1 = IW'(i);
          w_w1   = i_wt[i*W +: W];
          w_f1   = 1'b1;
        end else if (!w_f2 || i_wt[i*W +: W] < w_w2) begin
          o_min2 = IW'(i);
          w_w2   = i_wt[i*W +: W];
          w_f2   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/huff_encoder_param.sv
// huff_encoder_param: loads up to N symbols, builds the Huffman tree one merge per cycle,
// walks leaves to the root to form codes, then streams a (char, code, len) table.
module huff_encoder_param import huff_pkg::*; #(
  parameter int N      = 4,
  parameter int CHAR_W = 8,
  parameter int FREQ_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHAR_W-1:0]     in_char,
  input  logic [FREQ_W-1:0]     in_freq,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHAR_W-1:0]     out_char,
  output logic [N-2:0]          out_code,
  output logic [len_w(N)-1:0]   out_len,
  output logic                  done
);
  localparam int W_W    = w_w(N, FREQ_W);
  localparam int CODE_W = N - 1;
  localparam int LEN_W  = len_w(N);
  localparam int M      = 2 * N - 1;
  localparam int IW     = idx_w(N);
  localparam int KW     = $clog2(N + 1);
  localparam int LW     = $clog2(N);
  localparam int CW     = LEN_W;

  state_t             r_state, w_next;
  logic [KW-1:0]      r_k;
  logic [LW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [CHAR_W-1:0]  r_char [N];
  logic [IW-1:0]      r_cur  [N];
  logic [CODE_W-1:0]  r_code [N];
  logic [LEN_W-1:0]   r_len  [N];
  logic [W_W-1:0]     r_wt   [M];
  logic [IW-1:0]      r_par  [M];
  logic [M-1:0]       r_bit, r_hasp, r_act;
  logic [M*W_W-1:0]   w_wt_flat;
  logic [IW-1:0]      w_m1, w_m2, w_new, w_kn;
  logic [LW-1:0]      w_kl;
  logic               w_beat, w_last_beat, w_mdone, w_wdone, w_acc, w_end;

  for (genvar g = 0; g < M; g++) begin : g_flat
    assign w_wt_flat[g*W_W +: W_W] = r_wt[g];
  end

  huff_min2_finder #(.M(M), .W(W_W), .IW(IW)) u_min2 (
    .i_wt   (w_wt_flat),
    .i_act  (r_act),
    .o_min1 (w_m1),
    .o_min2 (w_m2)
  );

  assign in_ready    = r_state == S_IDLE || r_state == S_LOAD;
  assign w_beat      = in_valid && in_ready;
  assign w_last_beat = w_beat && (in_last || r_k == KW'(N - 1));
  assign w_kl        = LW'(r_k);
  assign w_kn        = IW'(r_k);
  assign w_new       = IW'(N) + IW'(r_cnt);
  // MERGE spends one extra cycle after the K-1 merges, so K=1 still passes through it
  assign w_mdone     = int'(r_cnt) >= int'(r_k) - 1;
  assign w_wdone     = r_cnt == CW'(CODE_W - 1);
  assign w_acc       = r_state == S_EMIT && out_ready;
  assign w_end       = w_acc && KW'(r_idx) == r_k - KW'(1);
  assign out_valid   = r_state == S_EMIT;
  assign out_char    = out_valid ? r_char[r_idx] : '0;
  assign out_code    = out_valid ? r_code[r_idx] : '0;
  assign out_len     = !out_valid ? '0 : r_len[r_idx] == '0 ? LEN_W'(1) : r_len[r_idx];
  assign done        = r_done;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_LOAD: w_next = w_last_beat ? S_MERGE : w_beat ? S_LOAD : r_state;
      S_MERGE:        w_next = w_mdone ? S_WALK : S_MERGE;
      S_WALK:         w_next = w_wdone ? S_EMIT : S_WALK;
      S_EMIT:         w_next = w_end ? S_IDLE : S_EMIT;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_k    <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_bit  <= '0;
      r_hasp <= '0;
      r_act  <= '0;
      for (int i = 0; i < M; i++) begin
        r_wt[i]  <= '0;
        r_par[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        r_char[i] <= '0;
        r_cur[i]  <= '0;
        r_code[i] <= '0;
        r_len[i]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (w_beat) begin
        r_char[w_kl] <= in_char;
        r_cur[w_kl]  <= w_kn;
        r_code[w_kl] <= '0;
        r_len[w_kl]  <= '0;
        r_wt[w_kn]   <= W_W'(in_freq);
        r_act[w_kn]  <= 1'b1;
        r_hasp[w_kn] <= 1'b0;
        r_k          <= r_k + KW'(1);
        r_cnt        <= '0;
      end
      if (r_state == S_MERGE) begin
        if (w_mdone) r_cnt <= '0;
        else begin
          r_wt[w_new]   <= r_wt[w_m1] + r_wt[w_m2];
          r_act[w_new]  <= 1'b1;
          r_hasp[w_new] <= 1'b0;
          r_act[w_m1]   <= 1'b0;
          r_act[w_m2]   <= 1'b0;
          r_hasp[w_m1]  <= 1'b1;
          r_hasp[w_m2]  <= 1'b1;
          r_par[w_m1]   <= w_new;
          r_par[w_m2]   <= w_new;
          r_bit[w_m1]   <= 1'b0;
          r_bit[w_m2]   <= 1'b1;
          r_cnt         <= r_cnt + CW'(1);
        end
      end
      if (r_state == S_WALK) begin
        r_cnt <= r_cnt + CW'(1);
        // each climb adds the next bit above those already collected
        for (int i = 0; i < N; i++)
          if (i < int'(r_k) && r_hasp[r_cur[i]]) begin
            r_code[i] <= r_code[i] | (CODE_W'(r_bit[r_cur[i]]) << r_len[i]);
            r_len[i]  <= r_len[i] + LEN_W'(1);
            r_cur[i]  <= r_par[r_cur[i]];
          end
      end
      if (w_acc) begin
        r_idx <= r_idx + LW'(1);
        if (w_end) begin
          r_idx  <= '0;
          r_k    <= '0;
          r_done <= 1'b1;
          r_act  <= '0;
          r_hasp <= '0;
        end
      end
    end
endmodule
